// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Shares the single main-memory port between iCache refills (IBEATS x 32-bit
//   beats) and dCache refills/writebacks (DBEATS x 32-bit beats). One requester
//   owns the port at a time. A burst runs beat by beat until the last beat is
//   acknowledged, then a one-cycle done pulse is issued to the owner.
//
// Ports
//   CLK, RST_N             clock (posedge) and synchronous active-low reset
//   i_req/i_addr           iCache refill request and miss address
//   i_gnt/i_rvalid/i_rdata iCache grant, beat-valid strobe and beat data
//   i_done                 one-cycle pulse after the last iCache beat
//   d_req/d_we/d_addr      dCache request, direction (1 = writeback), address
//   d_wdata/d_wready       writeback beat data and its per-beat accept strobe
//   d_gnt/d_rvalid/d_rdata dCache grant, beat-valid strobe and beat data
//   d_done                 one-cycle pulse after the last dCache beat
//   beat                   index of the current beat within the burst
//   mem_req/mem_we         beat request and direction to memory
//   mem_addr/mem_wdata     beat word address and write data
//   mem_ack/mem_rdata      beat accept and read data (same cycle as ack)
module cache_mem_arbiter #(
    parameter int IBEATS = 4,
    parameter int DBEATS = 2,
    parameter int BEAT_W = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_wready,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_done,
    output logic [BEAT_W-1:0] beat,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, IRD, DRD, DWR} state_t;

    state_t            state_q;
    state_t            state_nxt;
    logic [BEAT_W-1:0] beat_q;
    logic [31:0]       base_q;
    logic              last_i_q;   // 1 = iCache was granted most recently
    logic              i_done_q;
    logic              d_done_q;
    logic              last_beat;
    logic              burst_end;

    always_comb begin
        last_beat = 1'b0;
        case (state_q)
            IRD:      last_beat = (beat_q == BEAT_W'(IBEATS - 1));
            DRD, DWR: last_beat = (beat_q == BEAT_W'(DBEATS - 1));
            default:  last_beat = 1'b0;
        endcase
    end

    assign burst_end = (state_q != IDLE) && mem_ack && last_beat;

    // State register, beat counter, done pulses and round-robin flag
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            last_i_q <= 1'b1;
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            i_done_q <= burst_end && (state_q == IRD);
            d_done_q <= burst_end && (state_q != IRD);
            if (burst_end) begin
                beat_q   <= '0;
                last_i_q <= (state_q == IRD);
            end else if ((state_q != IDLE) && mem_ack) begin
                beat_q <= beat_q + BEAT_W'(1);
            end
        end
    end

    // Burst base address, captured on the grant edge and aligned to the block
    always_ff @(posedge CLK) begin
        if (state_q == IDLE) begin
            if (state_nxt == IRD)
                base_q <= i_addr & ~32'hF;
            else if (state_nxt != IDLE)
                base_q <= d_addr & ~32'h7;
        end
    end

    // Next-state: the cycle showing a done pulse is a mandatory dead cycle so
    // a requester that still holds its request cannot be re-granted for the
    // burst that just finished.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: begin
                if (!(i_done_q || d_done_q)) begin
                    if (i_req && (!d_req || !last_i_q))
                        state_nxt = IRD;
                    else if (d_req)
                        state_nxt = d_we ? DWR : DRD;
                end
            end
            default: begin
                if (burst_end)
                    state_nxt = IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        i_gnt    = (state_q == IRD);
        d_gnt    = (state_q == DRD) || (state_q == DWR);
        mem_req  = (state_q != IDLE);
        mem_we   = (state_q == DWR);
        i_rvalid = (state_q == IRD) && mem_ack;
        d_rvalid = (state_q == DRD) && mem_ack;
        d_wready = (state_q == DWR) && mem_ack;
        mem_addr = base_q + {{(30 - BEAT_W){1'b0}}, beat_q, 2'b00};
    end

    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign mem_wdata = d_wdata;
    assign i_done    = i_done_q;
    assign d_done    = d_done_q;
    assign beat      = beat_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: inputs change 1 time unit after the
// rising edge, outputs are observed on the falling edge.
module tb_cache_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        i_req, i_gnt, i_rvalid, i_done;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_wready, d_gnt, d_rvalid, d_done;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [1:0]  beat;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    cache_mem_arbiter #(.IBEATS(4), .DBEATS(2), .BEAT_W(2)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wready(d_wready), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_done(d_done), .beat(beat),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic to_drive();
        @(posedge CLK);
        #1;
    endtask

    task automatic to_check();
        @(negedge CLK);
    endtask

    initial begin
        RST_N = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;

        // Reset state
        to_check();
        chk1("rst_i_gnt", i_gnt, 1'b0);
        chk1("rst_d_gnt", d_gnt, 1'b0);
        chk1("rst_mem_req", mem_req, 1'b0);
        chk32("rst_beat", 32'(beat), 32'd0);
        chk1("rst_i_done", i_done, 1'b0);
        chk1("rst_d_done", d_done, 1'b0);

        // 1: iCache refill, ack every cycle
        to_drive(); RST_N = 1'b1; i_req = 1'b1; i_addr = 32'h0000_1238; mem_ack = 1'b1;
        to_check();
        chk1("t1_idle_gnt", i_gnt, 1'b0);
        chk1("t1_idle_req", mem_req, 1'b0);
        for (int k = 0; k < 4; k++) begin
            to_drive(); mem_rdata = 32'hA5A5_0000 + 32'(k);
            to_check();
            chk1("t1_gnt", i_gnt, 1'b1);
            chk1("t1_d_gnt", d_gnt, 1'b0);
            chk1("t1_we", mem_we, 1'b0);
            chk32("t1_addr", mem_addr, 32'h0000_1230 + 32'(4 * k));
            chk32("t1_beat", 32'(beat), 32'(k));
            chk1("t1_rvalid", i_rvalid, 1'b1);
            chk32("t1_rdata", i_rdata, 32'hA5A5_0000 + 32'(k));
            chk1("t1_no_done", i_done, 1'b0);
        end
        to_drive(); i_req = 1'b0; mem_ack = 1'b0;
        to_check();
        chk1("t1_done", i_done, 1'b1);
        chk1("t1_done_gnt", i_gnt, 1'b0);
        chk1("t1_done_req", mem_req, 1'b0);
        chk32("t1_done_beat", 32'(beat), 32'd0);
        chk1("t1_done_rvalid", i_rvalid, 1'b0);
        to_drive();
        to_check();
        chk1("t1_done_pulse", i_done, 1'b0);

        // 2: dCache writeback, ack on alternate cycles
        to_drive(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_2004;
        to_check();
        chk1("t2_idle_gnt", d_gnt, 1'b0);
        for (int k = 0; k < 4; k++) begin
            to_drive(); mem_ack = (k % 2) == 1; d_wdata = 32'hD0D0_0000 + 32'(k / 2);
            to_check();
            chk1("t2_gnt", d_gnt, 1'b1);
            chk1("t2_we", mem_we, 1'b1);
            chk1("t2_req", mem_req, 1'b1);
            chk32("t2_addr", mem_addr, 32'h0000_2000 + 32'(4 * (k / 2)));
            chk32("t2_beat", 32'(beat), 32'(k / 2));
            chk1("t2_wready", d_wready, (k % 2) == 1);
            chk32("t2_wdata", mem_wdata, 32'hD0D0_0000 + 32'(k / 2));
            chk1("t2_rvalid", d_rvalid, 1'b0);
            chk1("t2_no_done", d_done, 1'b0);
        end
        to_drive(); d_req = 1'b0; mem_ack = 1'b0;
        to_check();
        chk1("t2_done", d_done, 1'b1);
        chk1("t2_done_gnt", d_gnt, 1'b0);
        chk1("t2_done_we", mem_we, 1'b0);

        // 3: contention after reset, both requests held: D, I, D
        to_drive(); RST_N = 1'b0;
        to_check();
        to_drive(); RST_N = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        i_addr = 32'h0000_4014; d_addr = 32'h0000_300C; mem_ack = 1'b1;
        to_check();
        chk1("t3_idle_i", i_gnt, 1'b0);
        chk1("t3_idle_d", d_gnt, 1'b0);
        for (int k = 0; k < 2; k++) begin
            to_drive(); mem_rdata = 32'hC0DE_0000 + 32'(k);
            to_check();
            chk1("t3_d1_gnt", d_gnt, 1'b1);
            chk1("t3_d1_i_gnt", i_gnt, 1'b0);
            chk32("t3_d1_addr", mem_addr, 32'h0000_3008 + 32'(4 * k));
            chk1("t3_d1_rvalid", d_rvalid, 1'b1);
            chk1("t3_d1_i_rvalid", i_rvalid, 1'b0);
            chk32("t3_d1_rdata", d_rdata, 32'hC0DE_0000 + 32'(k));
        end
        to_drive();
        to_check();
        chk1("t3_d1_done", d_done, 1'b1);
        chk1("t3_d1_done_i", i_gnt, 1'b0);
        chk1("t3_d1_done_d", d_gnt, 1'b0);
        to_drive();
        to_check();
        chk1("t3_gap_done", d_done, 1'b0);
        chk1("t3_gap_i", i_gnt, 1'b0);
        chk1("t3_gap_d", d_gnt, 1'b0);
        chk1("t3_gap_req", mem_req, 1'b0);
        for (int k = 0; k < 4; k++) begin
            to_drive();
            to_check();
            chk1("t3_i_gnt", i_gnt, 1'b1);
            chk1("t3_i_d_gnt", d_gnt, 1'b0);
            chk32("t3_i_addr", mem_addr, 32'h0000_4010 + 32'(4 * k));
            chk1("t3_i_rvalid", i_rvalid, 1'b1);
        end
        to_drive();
        to_check();
        chk1("t3_i_done", i_done, 1'b1);
        chk1("t3_i_done_gnt", i_gnt, 1'b0);
        to_drive();
        to_check();
        chk1("t3_gap2_i", i_gnt, 1'b0);
        chk1("t3_gap2_d", d_gnt, 1'b0);
        for (int k = 0; k < 2; k++) begin
            to_drive();
            to_check();
            chk1("t3_d2_gnt", d_gnt, 1'b1);
            chk1("t3_d2_i_gnt", i_gnt, 1'b0);
            chk32("t3_d2_addr", mem_addr, 32'h0000_3008 + 32'(4 * k));
        end
        to_drive(); i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
        to_check();
        chk1("t3_d2_done", d_done, 1'b1);
        to_drive();
        to_check();
        chk1("t3_end_i", i_gnt, 1'b0);
        chk1("t3_end_d", d_gnt, 1'b0);

        // 4: reset in the middle of an iCache burst, then a fresh burst
        to_drive(); i_req = 1'b1; i_addr = 32'h0000_5008; mem_ack = 1'b1;
        to_check();
        for (int k = 0; k < 2; k++) begin
            to_drive();
            to_check();
            chk32("t4_addr", mem_addr, 32'h0000_5000 + 32'(4 * k));
            chk32("t4_beat", 32'(beat), 32'(k));
        end
        to_drive(); RST_N = 1'b0; mem_ack = 1'b0;
        to_check();
        chk32("t4_pre_beat", 32'(beat), 32'd2);
        chk1("t4_pre_gnt", i_gnt, 1'b1);
        to_drive(); RST_N = 1'b1; i_addr = 32'h0000_6004; mem_ack = 1'b1;
        to_check();
        chk1("t4_rst_gnt", i_gnt, 1'b0);
        chk1("t4_rst_req", mem_req, 1'b0);
        chk32("t4_rst_beat", 32'(beat), 32'd0);
        chk1("t4_rst_no_done", i_done, 1'b0);
        for (int k = 0; k < 4; k++) begin
            to_drive();
            to_check();
            chk1("t4_new_gnt", i_gnt, 1'b1);
            chk32("t4_new_addr", mem_addr, 32'h0000_6000 + 32'(4 * k));
            chk32("t4_new_beat", 32'(beat), 32'(k));
            chk1("t4_new_no_done", i_done, 1'b0);
        end
        to_drive(); i_req = 1'b0; mem_ack = 1'b0;
        to_check();
        chk1("t4_new_done", i_done, 1'b1);

        // 5: dCache refill with memory stalled for 10 cycles
        to_drive(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_7014;
        to_check();
        chk1("t5_idle_gnt", d_gnt, 1'b0);
        for (int k = 0; k < 10; k++) begin
            to_drive(); mem_rdata = 32'hBEEF_0000 + 32'(k);
            to_check();
            chk1("t5_stall_gnt", d_gnt, 1'b1);
            chk1("t5_stall_req", mem_req, 1'b1);
            chk1("t5_stall_we", mem_we, 1'b0);
            chk32("t5_stall_addr", mem_addr, 32'h0000_7010);
            chk32("t5_stall_beat", 32'(beat), 32'd0);
            chk1("t5_stall_rvalid", d_rvalid, 1'b0);
            chk32("t5_stall_rdata", d_rdata, 32'hBEEF_0000 + 32'(k));
        end
        for (int k = 0; k < 2; k++) begin
            to_drive(); mem_ack = 1'b1;
            to_check();
            chk32("t5_addr", mem_addr, 32'h0000_7010 + 32'(4 * k));
            chk1("t5_rvalid", d_rvalid, 1'b1);
        end
        to_drive(); d_req = 1'b0; mem_ack = 1'b0;
        to_check();
        chk1("t5_done", d_done, 1'b1);
        chk1("t5_done_gnt", d_gnt, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
